serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial WIDTH-bit subtractor (a - b), one bit per clock,
//            LSB first, built from a full-subtractor cell and a borrow flop.
//            Optional signed overflow flag when SERIAL_SUB_OVF_EN is defined;
//            otherwise ovf is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             sout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_rr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic w_accept;
  logic w_last;
  logic w_d;
  logic w_br_next;

  // start is only honoured while no operation is being shifted
  assign w_accept  = start && (r_state != S_SHIFT);
  assign w_last    = (r_state == S_SHIFT) && (r_cnt == C_LAST);

  // Full-subtractor cell on the current LSBs and the stored borrow
  assign w_d       = r_ra[0] ^ r_rb[0] ^ r_br;
  assign w_br_next = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_br);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode; sout is gated so it only shows a bit while shifting
  always_comb begin
    busy = (r_state == S_SHIFT);
    done = (r_state == S_DONE);
    sout = (r_state == S_SHIFT) & w_d;
  end

  // Operand shift registers, borrow flop, result shifter and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra  <= '0;
      r_rb  <= '0;
      r_rr  <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_ra  <= a;
      r_rb  <= b;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_ra  <= r_ra >> 1;
      r_rb  <= r_rb >> 1;
      r_rr  <= {w_d, r_rr[WIDTH-1:1]};
      r_br  <= w_br_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Results are captured only on the final bit so they hold between operations
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_last) begin
      r_diff <= {w_d, r_rr[WIDTH-1:1]};
      r_bout <= w_br_next;
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic r_sa;
  logic r_sb;
  logic r_ovf;

  // Operand signs are captured at acceptance; overflow is judged on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sa <= a[WIDTH-1];
        r_sb <= b[WIDTH-1];
      end
      if (w_last) r_ovf <= (r_sa ^ r_sb) & (w_d ^ r_sa);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (WIDTH = 8): directed
//            vector table, randomized operations against an arithmetic model,
//            back-to-back throughput and mid-operation reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bout, sout, ovf;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .sout(sout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  // Reference model: plain modular / signed arithmetic
  function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = (int'(x) - int'(y) + 256) % 256;
    return W'(r);
  endfunction

  function automatic logic m_bout(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_SUB_OVF_EN
    int sd;
    sd = int'($signed(x)) - int'($signed(y));
    return (sd > 127) || (sd < -128);
`else
    return (x != x);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete operation from idle; optional junk on start/a/b during SHIFT
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] ediff, input logic ebout,
                        input logic eovf, input bit junk);
    logic [W-1:0] sbits;
    sbits = '0;
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      chk("busy_shift", {31'd0, busy}, 32'd1);
      if (k > 0) chk("done_early", {31'd0, done}, 32'd0);
      sbits[k] = sout;
      if (junk) begin
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("diff", {24'd0, diff}, {24'd0, ediff});
    chk("bout", {31'd0, bout}, {31'd0, ebout});
    chk("ovf", {31'd0, ovf}, {31'd0, eovf});
    chk("sout_seq", {24'd0, sbits}, {24'd0, ediff});
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("diff_hold", {24'd0, diff}, {24'd0, ediff});
  endtask

  vec_t vecs[6];
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  initial begin
    vecs[0] = '{a: 8'd100, b: 8'd37,  diff: 8'd63,  bout: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd9,   diff: 8'hFC,  bout: 1'b1};
    vecs[2] = '{a: 8'h80,  b: 8'h01,  diff: 8'h7F,  bout: 1'b0};
    vecs[3] = '{a: 8'hFF,  b: 8'hFF,  diff: 8'h00,  bout: 1'b0};
    vecs[4] = '{a: 8'h00,  b: 8'hFF,  diff: 8'h01,  bout: 1'b1};
    vecs[5] = '{a: 8'h7F,  b: 8'h80,  diff: 8'hFF,  bout: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_sout", {31'd0, sout}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout,
             m_ovf(vecs[i].a, vecs[i].b), (i % 2) == 1);

    // Randomized operations against the model
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, m_diff(ra, rb), m_bout(ra, rb), m_ovf(ra, rb), $urandom_range(0, 1) == 1);
    end

    // Back-to-back: start held high, operands change every cycle.
    // Acceptance edges are 0, 9, 18; done after edges 8, 17, 26.
    start = 1'b1;
    for (int i = 0; i < 27; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      qa.push_back(a);
      qb.push_back(b);
      if (i == 26) start = 1'b0;
      @(posedge clk); #1;
      chk("b2b_done", {31'd0, done}, {31'd0, (i >= 8) && ((i - 8) % 9 == 0)});
      if ((i >= 8) && ((i - 8) % 9 == 0)) begin
        chk("b2b_diff", {24'd0, diff}, {24'd0, m_diff(qa[i-8], qb[i-8])});
        chk("b2b_bout", {31'd0, bout}, {31'd0, m_bout(qa[i-8], qb[i-8])});
        chk("b2b_ovf",  {31'd0, ovf},  {31'd0, m_ovf(qa[i-8], qb[i-8])});
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", {30'd0, busy, done}, 32'd0);

    // Reset 3 cycles into SHIFT after a result with nonzero outputs
    run_op(8'd5, 8'd9, 8'hFC, 1'b1, m_ovf(8'd5, 8'd9), 1'b0);
    a = 8'h80; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("irst_busy", {31'd0, busy}, 32'd0);
    chk("irst_done", {31'd0, done}, 32'd0);
    chk("irst_diff", {24'd0, diff}, 32'd0);
    chk("irst_bout", {31'd0, bout}, 32'd0);
    chk("irst_sout", {31'd0, sout}, 32'd0);
    chk("irst_ovf",  {31'd0, ovf},  32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("irst_no_done", {30'd0, busy, done}, 32'd0);
    end
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, m_ovf(8'h80, 8'h01), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
